// File: rtl/ram_mon_pkg.sv
// Shared command encodings, error-class indices and read-FSM states for the
// SPI-slave RAM protocol monitor.
package ram_mon_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int E_RST      = 0;
    localparam int E_STABLE   = 1;
    localparam int E_WR_ORDER = 2;
    localparam int E_RD_ORDER = 3;
    localparam int E_SPURIOUS = 4;
    localparam int E_TIMEOUT  = 5;
    localparam int E_DATA     = 6;
    localparam int N_ERR      = 7;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ram_mon_err_counter.sv
// Saturating per-class error counter; a clear coinciding with an increment
// leaves the counter at one so the coincident event is not lost.
module ram_mon_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ram_protocol_monitor.sv
// Protocol monitor for the SPI-slave RAM: command ordering, shadow-memory read
// prediction, read-latency bound, reset/stability checks and error reporting.
module ram_protocol_monitor
    import ram_mon_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int P_W     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_W+1:0]         din,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      dout,
    input  logic                   tx_valid,
    input  logic                   clr_cnt,
    output logic [N_ERR-1:0]       err_pulse,
    output logic [N_ERR*CNT_W-1:0] err_cnt,
    output logic                   err_sticky
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT_W = $clog2(MAX_LAT + 1);

    logic [1:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_wr_addr_cmd;
    logic              w_wr_data_cmd;
    logic              w_rd_addr_cmd;
    logic              w_rd_data_cmd;
    logic              w_wr_ok;

    logic [DATA_W-1:0] r_shadow [DEPTH];
    logic [DEPTH-1:0]  r_shadow_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_addr_vld;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_addr_vld;
    logic              r_first;
    logic [P_W+1:0]    r_din_prev;

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [LAT_W-1:0]  w_lat_next;
    logic [DATA_W-1:0] r_exp_data;
    logic [DATA_W-1:0] w_exp_data_next;
    logic              r_exp_vld;
    logic              w_exp_vld_next;

    logic [N_ERR-1:0]  w_err;
    logic [N_ERR-1:0]  r_err_pulse;
    logic              r_sticky;

    assign w_cmd         = din[P_W+1:P_W];
    assign w_addr        = din[ADDR_W-1:0];
    assign w_data        = din[DATA_W-1:0];
    assign w_wr_addr_cmd = rx_valid && (w_cmd == CMD_WR_ADDR);
    assign w_wr_data_cmd = rx_valid && (w_cmd == CMD_WR_DATA);
    assign w_rd_addr_cmd = rx_valid && (w_cmd == CMD_RD_ADDR);
    assign w_rd_data_cmd = rx_valid && (w_cmd == CMD_RD_DATA);
    assign w_wr_ok       = w_wr_data_cmd && r_wr_addr_vld;

    // Shadow contents are deliberately left unreset; only the valid bits are.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_shadow[r_wr_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_vld  <= '0;
            r_wr_addr     <= '0;
            r_wr_addr_vld <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_addr_vld <= 1'b0;
            r_first       <= 1'b1;
            r_din_prev    <= '0;
        end else begin
            r_first    <= 1'b0;
            r_din_prev <= din;
            if (w_wr_ok) begin
                r_shadow_vld[r_wr_addr] <= 1'b1;
            end
            if (w_wr_addr_cmd) begin
                r_wr_addr     <= w_addr;
                r_wr_addr_vld <= 1'b1;
            end
            if (w_rd_addr_cmd) begin
                r_rd_addr     <= w_addr;
                r_rd_addr_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RD_IDLE;
            r_lat_cnt   <= '0;
            r_exp_data  <= '0;
            r_exp_vld   <= 1'b0;
            r_err_pulse <= '0;
            r_sticky    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lat_cnt   <= w_lat_next;
            r_exp_data  <= w_exp_data_next;
            r_exp_vld   <= w_exp_vld_next;
            r_err_pulse <= w_err;
            r_sticky    <= clr_cnt ? (|w_err) : (r_sticky | (|w_err));
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_lat_next      = r_lat_cnt;
        w_exp_data_next = r_exp_data;
        w_exp_vld_next  = r_exp_vld;
        w_err           = '0;

        w_err[E_RST]      = r_first && (tx_valid || (dout != '0));
        w_err[E_STABLE]   = !r_first && !rx_valid && (din != r_din_prev);
        w_err[E_WR_ORDER] = w_wr_data_cmd && !r_wr_addr_vld;

        case (r_state)
            RD_IDLE: begin
                w_err[E_SPURIOUS] = tx_valid;
                if (w_rd_data_cmd) begin
                    if (r_rd_addr_vld) begin
                        w_exp_data_next = r_shadow[r_rd_addr];
                        w_exp_vld_next  = r_shadow_vld[r_rd_addr];
                        w_lat_next      = '0;
                        w_state_next    = RD_WAIT;
                    end else begin
                        w_err[E_RD_ORDER] = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (tx_valid) begin
                    w_err[E_DATA] = r_exp_vld && (dout != r_exp_data);
                    w_state_next  = RD_IDLE;
                    // Back-to-back read: the response above retires before the new request.
                    if (w_rd_data_cmd) begin
                        if (r_rd_addr_vld) begin
                            w_exp_data_next = r_shadow[r_rd_addr];
                            w_exp_vld_next  = r_shadow_vld[r_rd_addr];
                            w_lat_next      = '0;
                            w_state_next    = RD_WAIT;
                        end else begin
                            w_err[E_RD_ORDER] = 1'b1;
                        end
                    end
                end else begin
                    w_lat_next        = r_lat_cnt + 1'b1;
                    w_err[E_RD_ORDER] = w_rd_data_cmd;
                    if (r_lat_cnt == LAT_W'(MAX_LAT - 1)) begin
                        w_err[E_TIMEOUT] = 1'b1;
                        w_state_next     = RD_IDLE;
                    end
                end
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_ERR; gi++) begin : g_cnt
            ram_mon_err_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst_n(rst_n),
                .inc  (w_err[gi]),
                .clr  (clr_cnt),
                .cnt  (err_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_sticky;

endmodule

// File: doc/ram_protocol_monitor.md
# ram_protocol_monitor

Parametrised, synthesizable protocol monitor for the SPI-slave RAM interface. It replaces the fixed-width reset and stability property checks with an RTL monitor that works at any address or data width. It tracks command ordering, keeps a shadow memory to predict read data, enforces a read-latency bound, and reports violations as per-class pulses, saturating counters and a sticky flag. It sits beside the RAM, on the same `din`/`rx_valid`/`dout`/`tx_valid` nets, in both simulation and emulation builds.

## Interface
- `ADDR_W`, 8, address payload width; shadow depth is 2**ADDR_W
- `DATA_W`, 8, data payload width
- `P_W`, max(ADDR_W, DATA_W), payload width (derived, do not override)
- `MAX_LAT`, 4, maximum edges from read-data command to `tx_valid`; must be ≥1
- `CNT_W`, 8, width of each error counter
- `clk` in 1: single clock, all sampling on posedge
- `rst_n` in 1: asynchronous, active-low reset, shared with the RAM
- `din` in P_W+2: `din[P_W+1:P_W]` is the command; `din[P_W-1:0]` is the payload
- `rx_valid` in 1: command valid
- `dout` in DATA_W: RAM read data
- `tx_valid` in 1: RAM read data valid
- `clr_cnt` in 1: synchronous clear of counters and sticky flag
- `err_pulse` out N_ERR: one bit per error class, high for one cycle
- `err_cnt` out N_ERR*CNT_W: flattened per-class counters; class k occupies `[k*CNT_W +: CNT_W]`
- `err_sticky` out 1: set by any error, cleared only by reset or `clr_cnt`

## Operation
- Error classes, index order: E_RST=0, E_STABLE=1, E_WR_ORDER=2, E_RD_ORDER=3, E_SPURIOUS=4, E_TIMEOUT=5, E_DATA=6. N_ERR=7.
- Commands are sampled only when `rx_valid`=1.
  - 00: write address; sets `wr_addr` and `wr_addr_vld`.
  - 01: write data; writes `shadow[wr_addr]` and sets that entry's valid bit. If `wr_addr_vld`=0, no write happens and E_WR_ORDER is flagged.
  - 10: read address; sets `rd_addr` and `rd_addr_vld`.
  - 11: read data; payload is ignored.
- Read FSM, states RD_IDLE and RD_WAIT:
  - 11 in RD_IDLE with `rd_addr_vld`=1: capture the expected value `shadow[rd_addr]` and its valid bit, load the latency counter with 0, go to RD_WAIT.
  - 11 in RD_IDLE with `rd_addr_vld`=0: E_RD_ORDER; stay in RD_IDLE.
  - In RD_WAIT, `tx_valid`=1: compare `dout` to the expected value, only if the captured valid bit is set; a mismatch is E_DATA. Return to RD_IDLE.
  - In RD_WAIT with no `tx_valid`: increment the counter. At the edge where it reaches MAX_LAT, flag E_TIMEOUT and return to RD_IDLE.
  - 11 in RD_WAIT without `tx_valid` at the same edge: E_RD_ORDER; the request is dropped.
  - 11 and `tx_valid` at the same edge in RD_WAIT: the response is checked first, then the 11 is accepted as a new request with no error.
  - `tx_valid`=1 in RD_IDLE: E_SPURIOUS.
- E_RST: at the first posedge after reset deassertion, `tx_valid`≠0 or `dout`≠0.
- E_STABLE: `rx_valid`=0 and `din` differs from its value at the previous edge. This check is skipped at the first edge after reset.
- Counters:
  - On an error, increment and saturate at 2**CNT_W-1.
  - `clr_cnt` zeroes all counters and `err_sticky`.
  - If `clr_cnt` and an error occur at the same edge, that counter ends at 1 and `err_sticky` ends at 1.

## Timing
- All detections are registered. A violation sampled at edge N shows on `err_pulse` and the counter after edge N, for exactly one cycle.
- Multiple classes may pulse at the same edge.
- Read response window: a response is legal at edges N+1 through N+MAX_LAT after a 11 accepted at edge N.
- Expected data is a snapshot taken at acceptance. A later 01 to the same address during RD_WAIT does not change the expectation.
- Reset asynchronously clears:
  - `err_pulse`, `err_cnt`, `err_sticky` to 0
  - both address-valid flags and all shadow valid bits
  - FSM to RD_IDLE
  - the latency counter
  - sets the first-edge flag
- Shadow data is not reset.
- Reset in the middle of RD_WAIT abandons the request. No E_TIMEOUT is raised afterwards.

## Structure
- `ram_mon_pkg`:
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - error index constants and N_ERR
  - `rd_state_e` enum
- Sub-module `ram_mon_err_counter` (CNT_W; inputs `inc` and `clr`; saturating) is instantiated N_ERR times in a generate loop.
- Shadow memory is a flop array of DATA_W × 2**ADDR_W plus a 2**ADDR_W valid vector.

## Test plan
All scenarios use the default parameters.
- Reset, then commands 00 0x12, 01 0xAB, 10 0x12, 11; DUT returns `tx_valid` 2 edges later with `dout`=0xAB → no `err_pulse`; all counters 0.
- Same sequence but `dout`=0xAC → `err_pulse[6]` for one cycle, E_DATA counter =1, `err_sticky`=1.
- 11 accepted and no `tx_valid` for 4 edges → E_TIMEOUT pulse at the 4th edge; FSM is back in RD_IDLE, and `tx_valid` at the 5th edge → E_SPURIOUS.
- 01 issued first after reset → E_WR_ORDER, shadow unchanged. `din` changes 0x0FF→0x100 with `rx_valid`=0 → E_STABLE.
- 300 consecutive E_DATA events → counter holds 255. `clr_cnt` together with an error → counter 1, `err_sticky` 1.
- `rst_n` low mid-RD_WAIT → all outputs 0, no timeout afterwards. DUT drives `tx_valid`=1 at the first edge after release → E_RST and E_SPURIOUS.
